fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Fetch-stage controller directly upstream of the instruction memory.
- Generates the word-indexed `pc` that the instruction memory samples on each clock edge, and drives that memory's branch/flush input.
- Tags the memory's 1-cycle-latency `instruction` output with a valid bit and its own PC for decode.
- Handles boot, sequential fetch, stall hold, branch redirect and end-of-program halt.

Parameters:
- RESET_PC, 0: word index fetched first after reset.
- HALT_PC, 255: word index at which fetch stops; this index is never issued.
- PC_W, 32: width of all PC signals.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decode/hazard stall; hold current fetch
- branch  in  1  redirect request from execute, single-cycle pulse
- branch_target  in  PC_W  word index to fetch after redirect
- pc  out  PC_W  address to instruction memory (registered)
- imem_flush  out  1  to instruction memory `branch` input; equals `branch` combinationally
- fetch_valid  out  1  instruction memory output this cycle is a real instruction
- fetch_pc  out  PC_W  PC of the instruction currently on the memory output
- halted  out  1  fetch has reached HALT_PC
- fetch_count  out  32  retired-fetch counter (optional feature)
- flush_count  out  32  branch-flush counter (optional feature)

Behaviour:
- Reset (asynchronous, any time, including mid-branch or mid-stall):
  - state=BOOT, pc=RESET_PC, fetch_pc=RESET_PC, fetch_valid=0, halted=0, counters=0.
- States:
  - BOOT: one cycle. `pc` already holds RESET_PC, so the memory samples it at this edge.
    - Next: RUN. fetch_valid<=1, fetch_pc<=RESET_PC, pc<=RESET_PC+1.
    - If branch is asserted in BOOT: branch rule below applies instead.
  - RUN, priority branch > halt check > stall > advance:
    - branch: pc<=branch_target; fetch_valid<=0 (memory zeroes its output this edge); fetch_pc unchanged. Stall is ignored in the same cycle. Next cycle resumes normal fetch from the target, giving exactly one bubble.
    - stall (no branch): pc, fetch_pc and fetch_valid hold. The memory re-reads the same word, so its output is stable.
    - pc==HALT_PC (no branch): → HALTED; fetch_valid<=0; pc holds.
    - advance: fetch_pc<=pc; pc<=pc+1 (wraps modulo 2^PC_W); fetch_valid<=1.
  - HALTED: pc holds, fetch_valid=0, halted=1. A branch in this state is ignored. Exit is by rst only.
- A branch to branch_target==HALT_PC enters HALTED on the following cycle; no instruction is issued from HALT_PC.
- imem_flush is purely combinational from `branch`. There is no extra gating, so it must be glitch-free from a registered source.
- All other outputs are registered. Latency from pc to fetch_valid/fetch_pc is 1 cycle, matching the memory.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - fetch_count increments on each advance that sets fetch_valid<=1, including the BOOT→RUN transition.
  - flush_count increments on each accepted branch, in BOOT or RUN.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: no counter registers are built, and both ports are tied to 0.

Test Plan:
- Reset release with RESET_PC=0, no stall → pc sequence 0,1,2,3; fetch_valid 0 then 1 from cycle 2; fetch_pc trails pc by 1 (0,1,2).
- Branch pulse while pc=3, branch_target=9 → imem_flush=1 that cycle; next cycle pc=9, fetch_valid=0; following cycle fetch_pc=9, fetch_valid=1, pc=10; flush_count=1.
- Stall held 3 cycles at pc=5 → pc=5, fetch_pc=4, fetch_valid=1 constant; release → pc=6, fetch_pc=5.
- Branch and stall asserted together, target=2 → branch wins: pc=2, fetch_valid=0 next cycle.
- HALT_PC=11, free run from 0 → after fetch_pc=10 issued, halted=1, pc=11 held, fetch_valid=0; branch to 0 ignored; fetch_count=11.
- rst asserted mid-run at pc=7 → outputs return to reset values immediately (asynchronously, before the next clock edge); after release, fetch restarts at 0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: stall/branch requests in, registered PC and tagged-fetch status out.
// fetch_count/flush_count carry the optional performance counters.
interface fetch_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            branch;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pc;
  logic            imem_flush;
  logic            fetch_valid;
  logic [PC_W-1:0] fetch_pc;
  logic            halted;
  logic [31:0]     fetch_count;
  logic [31:0]     flush_count;

  modport master (
    output stall, branch, branch_target,
    input  pc, imem_flush, fetch_valid, fetch_pc, halted, fetch_count, flush_count
  );

  modport slave (
    input  stall, branch, branch_target,
    output pc, imem_flush, fetch_valid, fetch_pc, halted, fetch_count, flush_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: drives the instruction-memory PC and tags its 1-cycle-latency output.
// Defining FETCH_PERF_EN builds saturating fetch/flush counters; otherwise both read 0.
//
// state  | meaning
// BOOT   | memory is sampling RESET_PC; nothing valid yet
// RUN    | sequential fetch, stall hold, branch redirect
// HALTED | pc reached HALT_PC; only rst leaves this state
module fetch_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] HALT_PC  = 255
) (
  input  logic clk,
  input  logic rst,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [PC_W-1:0] fpc_q, fpc_nxt;
  logic            fv_q, fv_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
      fpc_q <= RESET_PC;
      fv_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      fpc_q <= fpc_nxt;
      fv_q  <= fv_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    fpc_nxt   = fpc_q;
    fv_nxt    = fv_q;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        if (bus.branch) begin
          pc_nxt = bus.branch_target;
          fv_nxt = 1'b0;
        end else begin
          fpc_nxt = RESET_PC;
          pc_nxt  = RESET_PC + PC_W'(1);
          fv_nxt  = 1'b1;
        end
      end
      RUN: begin
        // Memory clears its output on a flush, so the redirect costs one bubble.
        if (bus.branch) begin
          pc_nxt = bus.branch_target;
          fv_nxt = 1'b0;
        end else if (pc_q == HALT_PC) begin
          state_nxt = HALTED;
          fv_nxt    = 1'b0;
        end else if (!bus.stall) begin
          fpc_nxt = pc_q;
          pc_nxt  = pc_q + PC_W'(1);
          fv_nxt  = 1'b1;
        end
      end
      HALTED: begin
        fv_nxt = 1'b0;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_pc    = fpc_q;
  assign bus.fetch_valid = fv_q;
  assign bus.halted      = (state == HALTED);
  assign bus.imem_flush  = bus.branch;

`ifdef FETCH_PERF_EN
  logic        adv, br_acc;
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  assign br_acc = bus.branch && (state != HALTED);
  assign adv    = !bus.branch && ((state == BOOT) ||
                  (state == RUN && pc_q != HALT_PC && !bus.stall));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (adv && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (br_acc && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_count = fetch_cnt_q;
  assign bus.flush_count = flush_cnt_q;
`else
  assign bus.fetch_count = '0;
  assign bus.flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl (RESET_PC=0, HALT_PC=11): vector table with a
// scoreboard queue, then hand-written async-reset and halt sequences.
module tb_fetch_ctrl;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic [31:0] pc;
    logic        fv;
    logic [31:0] fpc;
    logic        halted;
    logic [31:0] fc;
    logic [31:0] fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[32];
  int   nv = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  fetch_if #(.PC_W(32)) bus ();

  fetch_ctrl #(.PC_W(32), .RESET_PC(32'd0), .HALT_PC(32'd11)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic add(input logic st, input logic br, input int tg, input int pc,
                     input logic fv, input int fpc, input logic h, input int fc, input int fl);
    vecs[nv] = '{st, br, tg, pc, fv, fpc, h, fc, fl};
    nv++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, bus.pc, 32'd0);
    check({tag, "_fv"}, {31'd0, bus.fetch_valid}, 32'd0);
    check({tag, "_fpc"}, bus.fetch_pc, 32'd0);
    check({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
    check({tag, "_fcnt"}, bus.fetch_count, 32'd0);
    check({tag, "_flcnt"}, bus.flush_count, 32'd0);
  endtask

  initial begin
    vec_t e;
    int cyc;

    // inputs for one cycle | state after the following edge
    add(0, 0, 0,  1, 1, 0, 0, 1, 0);   // BOOT -> RUN
    add(0, 0, 0,  2, 1, 1, 0, 2, 0);
    add(0, 0, 0,  3, 1, 2, 0, 3, 0);
    add(0, 1, 9,  9, 0, 2, 0, 3, 1);   // branch at pc=3
    add(0, 0, 0, 10, 1, 9, 0, 4, 1);
    add(0, 1, 4,  4, 0, 9, 0, 4, 2);
    add(0, 0, 0,  5, 1, 4, 0, 5, 2);
    add(1, 0, 0,  5, 1, 4, 0, 5, 2);   // stall x3 at pc=5
    add(1, 0, 0,  5, 1, 4, 0, 5, 2);
    add(1, 0, 0,  5, 1, 4, 0, 5, 2);
    add(0, 0, 0,  6, 1, 5, 0, 6, 2);
    add(1, 1, 2,  2, 0, 5, 0, 6, 3);   // branch beats stall
    add(1, 0, 0,  2, 0, 5, 0, 6, 3);
    add(0, 0, 0,  3, 1, 2, 0, 7, 3);
    for (int k = 4; k <= 11; k++) add(0, 0, 0, k, 1, k - 1, 0, k + 4, 3);
    add(0, 0, 0, 11, 0, 10, 1, 15, 3); // reaches HALT_PC
    add(0, 1, 0, 11, 0, 10, 1, 15, 3); // branch ignored when halted
    add(1, 0, 0, 11, 0, 10, 1, 15, 3);

    bus.stall = 1'b0;
    bus.branch = 1'b0;
    bus.branch_target = '0;

    repeat (2) @(negedge clk);
    check_reset_vals("in_reset");
    rst = 1'b0;
    #1 check_reset_vals("boot");

    for (int i = 0; i < nv; i++) begin
      bus.stall = vecs[i].stall;
      bus.branch = vecs[i].branch;
      bus.branch_target = vecs[i].target;
      #1 check($sformatf("v%0d_flush", i), {31'd0, bus.imem_flush}, {31'd0, vecs[i].branch});
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_pc", i), bus.pc, e.pc);
      check($sformatf("v%0d_fv", i), {31'd0, bus.fetch_valid}, {31'd0, e.fv});
      check($sformatf("v%0d_fpc", i), bus.fetch_pc, e.fpc);
      check($sformatf("v%0d_halted", i), {31'd0, bus.halted}, {31'd0, e.halted});
      check($sformatf("v%0d_fcnt", i), bus.fetch_count, PERF ? e.fc : 32'd0);
      check($sformatf("v%0d_flcnt", i), bus.flush_count, PERF ? e.fl : 32'd0);
      @(negedge clk);
    end
    bus.stall = 1'b0;
    bus.branch = 1'b0;

    // Restart, run to pc=7, then reset asynchronously mid-cycle.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_pc", bus.pc, 32'd7);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("restart_pc", bus.pc, 32'd1);
    check("restart_fpc", bus.fetch_pc, 32'd0);
    check("restart_fv", {31'd0, bus.fetch_valid}, 32'd1);

    // Free run to halt with a bounded cycle budget.
    cyc = 0;
    while (!bus.halted && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("halt_reached", {31'd0, bus.halted}, 32'd1);
    check("halt_pc", bus.pc, 32'd11);
    check("halt_fpc", bus.fetch_pc, 32'd10);
    check("halt_fv", {31'd0, bus.fetch_valid}, 32'd0);
    check("halt_fcnt", bus.fetch_count, PERF ? 32'd11 : 32'd0);
    check("halt_flcnt", bus.flush_count, 32'd0);

    // Branch to HALT_PC from the boot state: one bubble, then halt without issuing 11.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.branch = 1'b1;
    bus.branch_target = 32'd11;
    @(posedge clk);
    #1 check("bb_pc", bus.pc, 32'd11);
    check("bb_fv", {31'd0, bus.fetch_valid}, 32'd0);
    check("bb_flcnt", bus.flush_count, PERF ? 32'd1 : 32'd0);
    @(negedge clk);
    bus.branch = 1'b0;
    @(posedge clk);
    #1 check("bb_halted", {31'd0, bus.halted}, 32'd1);
    check("bb_fv2", {31'd0, bus.fetch_valid}, 32'd0);
    check("bb_fcnt", bus.fetch_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
